// File: rtl/sr_stack_engine.sv
// PUSH/POP sequencer on an empty-descending stack: reads SSP from the SR file, does one memory access, writes SSP back.
// Define SR_STACK_BOUNDS_EN to enable overflow/underflow detection; the default build has no checks and ow_err stays 0.
module sr_stack_engine #(
    parameter int unsigned       DATA_W      = 24,
    parameter int unsigned       SR_AW       = 4,
    parameter logic [SR_AW-1:0]  INDEX_SSP   = 4'd1,
    parameter logic [DATA_W-1:0] STACK_TOP   = 24'h000FFF,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 24'h000F00
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_req_valid,
    input  logic              iw_req_op,
    input  logic [DATA_W-1:0] iw_push_data,
    output logic              ow_req_ready,
    output logic              ow_done,
    output logic              ow_err,
    output logic [DATA_W-1:0] ow_pop_data,
    output logic [SR_AW-1:0]  ow_sr_read_addr,
    input  logic [DATA_W-1:0] iw_sr_read_data,
    output logic [SR_AW-1:0]  ow_sr_write_addr,
    output logic [DATA_W-1:0] ow_sr_write_data,
    output logic              ow_sr_write_enable,
    output logic              ow_mem_req,
    output logic              ow_mem_we,
    output logic [DATA_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic              iw_mem_ack,
    input  logic [DATA_W-1:0] iw_mem_rdata
);

`ifdef SR_STACK_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RDSP = 3'd1;
    localparam logic [2:0] S_MEM  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;

    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_out_q, err_out_d;
    logic              sr_we_q, sr_we_d;
    logic [DATA_W-1:0] sr_wdata_q, sr_wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;

    logic              bound_hit_c;

    // Full/empty test on the SSP value presented during RDSP
    assign bound_hit_c = BOUNDS_EN && (op_q ? (iw_sr_read_data == STACK_TOP)
                                            : (iw_sr_read_data == STACK_LIMIT));

    // Next state, then the registered outputs derived from the state being entered
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        sp_d        = sp_q;
        err_d       = err_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        err_out_d   = 1'b0;
        sr_we_d     = 1'b0;
        sr_wdata_d  = sr_wdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop_data_d  = pop_data_q;

        case (state_q)
            S_IDLE: begin
                if (iw_req_valid) begin
                    op_d    = iw_req_op;
                    data_d  = iw_push_data;
                    err_d   = 1'b0;
                    state_d = S_RDSP;
                end
            end
            S_RDSP: begin
                sp_d = iw_sr_read_data;
                if (bound_hit_c) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (iw_mem_ack) begin
                    if (op_q) begin
                        pop_data_d = iw_mem_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        case (state_d)
            S_MEM: begin
                mem_req_d  = 1'b1;
                mem_we_d   = ~op_d;
                mem_addr_d = op_d ? (sp_d + ONE) : sp_d;
                if (!op_d) begin
                    mem_wdata_d = data_d;
                end
            end
            S_WB: begin
                sr_we_d    = 1'b1;
                sr_wdata_d = op_d ? (sp_d + ONE) : (sp_d - ONE);
            end
            S_DONE: begin
                done_d    = 1'b1;
                err_out_d = err_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            data_q      <= '0;
            sp_q        <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_out_q   <= 1'b0;
            sr_we_q     <= 1'b0;
            sr_wdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pop_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            sp_q        <= sp_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_out_q   <= err_out_d;
            sr_we_q     <= sr_we_d;
            sr_wdata_q  <= sr_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pop_data_q  <= pop_data_d;
        end
    end

    assign ow_req_ready       = ready_q;
    assign ow_done            = done_q;
    assign ow_err             = err_out_q;
    assign ow_pop_data        = pop_data_q;
    assign ow_sr_read_addr    = INDEX_SSP;
    assign ow_sr_write_addr   = INDEX_SSP;
    assign ow_sr_write_data   = sr_wdata_q;
    assign ow_sr_write_enable = sr_we_q;
    assign ow_mem_req         = mem_req_q;
    assign ow_mem_we          = mem_we_q;
    assign ow_mem_addr        = mem_addr_q;
    assign ow_mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_sr_stack_engine.sv
// Randomized bench for sr_stack_engine: SR-file and memory models plus a timeline/scoreboard reference.
// Honours SR_STACK_BOUNDS_EN the same way the design does.
module tb_sr_stack_engine;

`ifdef SR_STACK_BOUNDS_EN
    localparam bit BND = 1'b1;
`else
    localparam bit BND = 1'b0;
`endif
    localparam logic [23:0] TOP   = 24'h000FFF;
    localparam logic [23:0] LIMIT = 24'h000F00;
    localparam logic [3:0]  IDX   = 4'd1;

    logic        iw_clk, iw_rst;
    logic        iw_req_valid, iw_req_op;
    logic [23:0] iw_push_data;
    logic        ow_req_ready, ow_done, ow_err;
    logic [23:0] ow_pop_data;
    logic [3:0]  ow_sr_read_addr, ow_sr_write_addr;
    logic [23:0] iw_sr_read_data, ow_sr_write_data;
    logic        ow_sr_write_enable, ow_mem_req, ow_mem_we;
    logic [23:0] ow_mem_addr, ow_mem_wdata;
    logic        iw_mem_ack;
    logic [23:0] iw_mem_rdata;

    sr_stack_engine dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_req_valid(iw_req_valid), .iw_req_op(iw_req_op), .iw_push_data(iw_push_data),
        .ow_req_ready(ow_req_ready), .ow_done(ow_done), .ow_err(ow_err), .ow_pop_data(ow_pop_data),
        .ow_sr_read_addr(ow_sr_read_addr), .iw_sr_read_data(iw_sr_read_data),
        .ow_sr_write_addr(ow_sr_write_addr), .ow_sr_write_data(ow_sr_write_data),
        .ow_sr_write_enable(ow_sr_write_enable),
        .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr),
        .ow_mem_wdata(ow_mem_wdata), .iw_mem_ack(iw_mem_ack), .iw_mem_rdata(iw_mem_rdata)
    );

    initial iw_clk = 1'b0;
    always #5 iw_clk = ~iw_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge iw_clk) cyc <= cyc + 1;

    // SR file holding the SSP; another agent may overwrite it while the engine is idle
    logic [23:0] sr_ssp = 24'h000FFF;
    logic        sr_force = 1'b0;
    logic [23:0] sr_force_val = '0;
    always @(posedge iw_clk) begin
        if (sr_force) sr_ssp <= sr_force_val;
        else if (ow_sr_write_enable && ow_sr_write_addr == IDX) sr_ssp <= ow_sr_write_data;
    end
    assign iw_sr_read_data = (ow_sr_read_addr == IDX) ? sr_ssp : 24'hDEAD00;

    logic [23:0] mem_b [bit [23:0]];
    logic [23:0] mem_m [bit [23:0]];
    logic [23:0] ssp_m = 24'h000FFF;
    logic [23:0] pop_m = '0;

    // Expected timeline of the current transaction, relative to the accept edge
    bit          run_chk = 1'b0;
    bit          txn_on = 1'b0;
    int          acc_cyc = 0;
    int          w_m = 0;
    int          end_m = 0;
    bit          err_m = 1'b0;
    bit          op_m = 1'b0;
    logic [23:0] addr_m = '0, wdata_m = '0, sr_m = '0;
    int          req_cnt = 0, sr_cnt = 0, last_lat = -1;
    bit          err_seen = 1'b0;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] dflt(input logic [23:0] a);
        return a ^ 24'h5A5A5A;
    endfunction

    // Per-cycle comparison against the expected timeline
    always @(negedge iw_clk) begin
        int  rel;
        bit  in_txn, e_req, e_sr, e_done;
        if (run_chk && !iw_rst) begin
            rel    = cyc - acc_cyc;
            in_txn = txn_on && rel >= 0 && rel <= end_m;
            e_req  = in_txn && !err_m && rel >= 1 && rel <= 1 + w_m;
            e_sr   = in_txn && !err_m && rel == 2 + w_m;
            e_done = in_txn && rel == end_m;
            if (txn_on && rel == -1) begin
                req_cnt = 0; sr_cnt = 0; last_lat = -1; err_seen = 1'b0;
            end
            if (ow_mem_req) req_cnt++;
            if (ow_sr_write_enable) sr_cnt++;
            if (ow_done) begin last_lat = rel + 1; err_seen = ow_err; end
            chk("ready", 24'(ow_req_ready), 24'(!in_txn));
            chk("done", 24'(ow_done), 24'(e_done));
            chk("err", 24'(ow_err), 24'(e_done && err_m));
            chk("mem_req", 24'(ow_mem_req), 24'(e_req));
            chk("sr_we", 24'(ow_sr_write_enable), 24'(e_sr));
            chk("sr_addrs", {16'h0, ow_sr_read_addr, ow_sr_write_addr}, {16'h0, IDX, IDX});
            if (e_req) begin
                chk("mem_we", 24'(ow_mem_we), 24'(!op_m));
                chk("mem_addr", ow_mem_addr, addr_m);
                if (!op_m) chk("mem_wdata", ow_mem_wdata, wdata_m);
            end
            if (e_sr) chk("sr_wdata", ow_sr_write_data, sr_m);
            if (e_done) chk("pop_data", ow_pop_data, pop_m);
        end
    end

    task automatic set_ssp(input logic [23:0] v);
        sr_force_val = v;
        sr_force = 1'b1;
        @(posedge iw_clk); #1;
        sr_force = 1'b0;
        ssp_m = v;
    endtask

    // Issue one request from an idle cycle (called at posedge+1) and play the memory side
    task automatic run_op(input bit op, input logic [23:0] d, input int w, input bit rst_mid);
        logic [23:0] ssp, pop_next;
        bit          aborted;
        ssp      = ssp_m;
        aborted  = 1'b0;
        op_m     = op;
        w_m      = w;
        err_m    = BND && (op ? (ssp == TOP) : (ssp == LIMIT));
        end_m    = err_m ? 1 : 3 + w;
        addr_m   = op ? ssp + 24'd1 : ssp;
        wdata_m  = d;
        sr_m     = op ? ssp + 24'd1 : ssp - 24'd1;
        pop_next = mem_m.exists(addr_m) ? mem_m[addr_m] : dflt(addr_m);
        if (op && !err_m) pop_m = pop_next;
        acc_cyc  = cyc + 1;
        txn_on   = 1'b1;
        iw_req_valid = 1'b1; iw_req_op = op; iw_push_data = d;
        @(posedge iw_clk); #1;
        for (int r = 0; r <= end_m; r++) begin
            iw_req_valid = 1'($urandom_range(0, 1));
            iw_req_op    = 1'($urandom);
            iw_push_data = 24'($urandom);
            if (!err_m && r >= 1 && r <= w) begin
                iw_mem_ack = 1'b0;
            end else if (!err_m && r == 1 + w) begin
                iw_mem_ack = 1'b1;
                if (ow_mem_we) mem_b[ow_mem_addr] = ow_mem_wdata;
                else iw_mem_rdata = mem_b.exists(ow_mem_addr) ? mem_b[ow_mem_addr] : dflt(ow_mem_addr);
            end else begin
                iw_mem_ack   = 1'($urandom);
                iw_mem_rdata = 24'($urandom);
            end
            if (rst_mid && r == 2) begin
                #2 iw_rst = 1'b1; iw_req_valid = 1'b0;
                #1;
                chk("rst_mem_req", 24'(ow_mem_req), 24'd0);
                chk("rst_ready", 24'(ow_req_ready), 24'd1);
                chk("rst_sr_we", 24'(ow_sr_write_enable), 24'd0);
                txn_on = 1'b0;
                pop_m  = '0;
                repeat (2) @(posedge iw_clk);
                #1 iw_rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge iw_clk); #1;
        end
        iw_req_valid = 1'b0;
        iw_mem_ack   = 1'b0;
        if (!aborted && !err_m) begin
            if (!op) mem_m[ssp] = d;
            ssp_m = sr_m;
        end
        chk("ssp_after", sr_ssp, ssp_m);
    endtask

    initial begin
        iw_rst = 1'b1;
        iw_req_valid = 1'b0; iw_req_op = 1'b0; iw_push_data = '0;
        iw_mem_ack = 1'b0; iw_mem_rdata = '0;
        #3;
        chk("rst_ready", 24'(ow_req_ready), 24'd1);
        chk("rst_done", 24'(ow_done), 24'd0);
        chk("rst_err", 24'(ow_err), 24'd0);
        chk("rst_sr_we", 24'(ow_sr_write_enable), 24'd0);
        chk("rst_mem_req", 24'(ow_mem_req), 24'd0);
        chk("rst_mem_we", 24'(ow_mem_we), 24'd0);
        chk("rst_pop_data", ow_pop_data, 24'd0);
        chk("rst_sr_wdata", ow_sr_write_data, 24'd0);
        chk("rst_mem_addr", ow_mem_addr, 24'd0);
        chk("rst_mem_wdata", ow_mem_wdata, 24'd0);
        @(posedge iw_clk); #1;
        iw_rst  = 1'b0;
        run_chk = 1'b1;
        @(posedge iw_clk); #1;

        run_op(1'b0, 24'hABCDEF, 0, 1'b0);
        chk("push_lat", 24'(last_lat), 24'd4);
        chk("push_ssp", sr_ssp, 24'h000FFE);
        chk("push_mem", mem_b.exists(24'h000FFF) ? mem_b[24'h000FFF] : 24'h0, 24'hABCDEF);

        run_op(1'b1, 24'h0, 0, 1'b0);
        chk("pop_lat", 24'(last_lat), 24'd4);
        chk("pop_data_lit", ow_pop_data, 24'hABCDEF);
        chk("pop_ssp", sr_ssp, 24'h000FFF);

        run_op(1'b1, 24'h0, 0, 1'b0);
        chk("pop_empty_lat", 24'(last_lat), BND ? 24'd2 : 24'd4);
        chk("pop_empty_err", 24'(err_seen), 24'(BND));
        chk("pop_empty_req", 24'(req_cnt), BND ? 24'd0 : 24'd1);
        chk("pop_empty_srwe", 24'(sr_cnt), BND ? 24'd0 : 24'd1);
        chk("pop_empty_ssp", sr_ssp, BND ? 24'h000FFF : 24'h001000);

        set_ssp(LIMIT);
        run_op(1'b0, 24'h123456, 1, 1'b0);
        chk("push_full_err", 24'(err_seen), 24'(BND));
        chk("push_full_req", 24'(req_cnt), BND ? 24'd0 : 24'd2);
        chk("push_full_ssp", sr_ssp, BND ? 24'h000F00 : 24'h000EFF);

        set_ssp(TOP);
        run_op(1'b0, 24'h5A0001, 3, 1'b0);
        chk("push_wait_lat", 24'(last_lat), 24'd7);
        chk("push_wait_req", 24'(req_cnt), 24'd4);

        run_op(1'b0, 24'h777777, 2, 1'b1);
        chk("rst_ssp_kept", sr_ssp, 24'h000FFE);
        @(posedge iw_clk); #1;
        run_op(1'b0, 24'h0BEEF0, 0, 1'b0);
        chk("post_rst_lat", 24'(last_lat), 24'd4);
        chk("post_rst_ssp", sr_ssp, 24'h000FFD);

        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                iw_mem_ack = 1'($urandom);
                @(posedge iw_clk); #1;
            end
            iw_mem_ack = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: set_ssp(TOP);
                    1: set_ssp(LIMIT);
                    2: set_ssp(LIMIT + 24'd1);
                    3: set_ssp(TOP - 24'd1);
                    default: set_ssp(24'($urandom));
                endcase
            end
            run_op(1'($urandom), 24'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(posedge iw_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_stack_engine.md
Name: sr_stack_engine

Overview:
- Sequencer that drives the special-register file as its client: reads the system stack pointer (SSP), performs one data-memory access, and writes the updated SSP back.
- Executes one PUSH or POP per request on an empty-descending stack.
- Sits between the execute stage and the data-memory port; the execute stage stalls on ow_req_ready.

Parameters:
- DATA_W, 24, data, stack-pointer and memory-address width.
- SR_AW, 4, special-register index width.
- INDEX_SSP, 4'd1, SR index of the SSP.
- STACK_TOP, 24'h000FFF, empty SSP value; matches the SR file's SSP reset value.
- STACK_LIMIT, 24'h000F00, full SSP value; usable cells are STACK_LIMIT+1..STACK_TOP (255 entries).

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset, asynchronous, active-high
- iw_req_valid  in  1  request present
- iw_req_op  in  1  0 = PUSH, 1 = POP
- iw_push_data  in  DATA_W  data to push
- ow_req_ready  out  1  engine idle, can accept a request
- ow_done  out  1  one-cycle completion pulse
- ow_err  out  1  qualifies ow_done: overflow or underflow
- ow_pop_data  out  DATA_W  popped word, valid with ow_done
- ow_sr_read_addr  out  SR_AW  constant INDEX_SSP
- iw_sr_read_data  in  DATA_W  SR read data, combinational
- ow_sr_write_addr  out  SR_AW  constant INDEX_SSP
- ow_sr_write_data  out  DATA_W  new SSP
- ow_sr_write_enable  out  1  one-cycle SSP write strobe
- ow_mem_req  out  1  memory request, held until ack
- ow_mem_we  out  1  1 = write, 0 = read
- ow_mem_addr  out  DATA_W  memory address
- ow_mem_wdata  out  DATA_W  memory write data
- iw_mem_ack  in  1  memory accepted / read data valid
- iw_mem_rdata  in  DATA_W  read data, valid with ack

Behaviour:
- Reset: the asynchronous iw_rst forces state IDLE. ow_req_ready=1. ow_done, ow_err, ow_sr_write_enable, ow_mem_req and ow_mem_we are 0. ow_pop_data, ow_sr_write_data, ow_mem_addr and ow_mem_wdata are 0. All internal latches are 0.
- Reset mid-operation: the memory request and SR write are dropped immediately, and no SSP update occurs.
- Handshake: a request is accepted on the rising edge when iw_req_valid && ow_req_ready. Op and data are latched at acceptance. Inputs are don't-care after acceptance. ow_req_ready=1 only in IDLE.
- State IDLE:
  - On acceptance, go to RDSP.
- State RDSP, one cycle:
  - Latch sp = iw_sr_read_data.
  - Check bounds:
    - PUSH with sp == STACK_LIMIT is an overflow.
    - POP with sp == STACK_TOP is an underflow.
  - On a bounds error, go to DONE with err=1, skipping MEM and WB.
  - Otherwise go to MEM.
- State MEM:
  - Assert ow_mem_req.
  - PUSH: ow_mem_we=1, addr=sp, wdata=latched data.
  - POP: ow_mem_we=0, addr=sp+1.
  - Hold req, we, addr and wdata stable until iw_mem_ack is sampled high.
  - On ack, a POP latches iw_mem_rdata. Then go to WB.
  - Ack may arrive in the first MEM cycle.
- State WB, one cycle:
  - Assert ow_sr_write_enable.
  - ow_sr_write_data = sp-1 for PUSH, sp+1 for POP.
  - Then go to DONE.
- State DONE, one cycle:
  - Pulse ow_done, with ow_err as computed.
  - ow_pop_data holds the popped word for POP. For PUSH or on error it is unchanged.
  - Then go to IDLE.
- Latency:
  - Accepted at edge N, with ack in the first MEM cycle: ow_done is high in cycle N+4, and the next accept is possible at edge N+5.
  - Each extra ack-wait cycle adds 1.
  - The error path finishes with ow_done in cycle N+2.
- Arithmetic: sp±1 is computed in DATA_W bits, modulo 2^DATA_W.
- iw_mem_ack outside MEM is ignored.
- Other SSP writers: other agents writing SSP while the engine is busy is illegal. The engine does not re-read the SSP after RDSP.

Optional Feature:
- SR_STACK_BOUNDS_EN defined:
  - Overflow and underflow checks are active as described above.
- SR_STACK_BOUNDS_EN undefined:
  - No checks are made, and ow_err is tied to 0.
  - PUSH at STACK_LIMIT and POP at STACK_TOP proceed normally, with pointer wrap modulo 2^DATA_W.
  - The parameters remain, but the limits are unused.

Test Plan:
- Reset, SSP=0x000FFF, PUSH 0xABCDEF, ack in the first MEM cycle -> mem write addr 0x000FFF data 0xABCDEF; SR write idx INDEX_SSP data 0x000FFE; ow_done in cycle N+4, err=0.
- Then POP, memory returns 0xABCDEF -> mem read addr 0x000FFF; SR write 0x000FFF; ow_done with ow_pop_data=0xABCDEF.
- POP with SSP=0x000FFF (bounds enabled) -> no ow_mem_req, no SR write; ow_done with ow_err=1 in cycle N+2. Without the macro -> mem read addr 0x001000, SSP=0x001000, err=0.
- PUSH with SSP=0x000F00 (bounds enabled) -> ow_err=1, SSP unchanged, no memory write.
- PUSH with ack delayed 3 cycles -> ow_mem_req, addr and wdata held stable for 4 cycles; ow_done in cycle N+7; iw_req_valid during the busy cycles is not accepted (ready=0).
- Assert iw_rst during MEM -> ow_mem_req=0 asynchronously, no SR write; after release ow_req_ready=1 and a following PUSH completes normally.
